// File: rtl/mips_bus_pkg.sv
// Shared types for the MIPS CPU bus arbiter: FSM states, grant owner, byte-enable constants.
// Latency: n/a (types and a pure combinational helper).
// Backpressure: n/a.
package mips_bus_pkg;

   typedef enum logic [1:0] {IDLE, REQ, RESP} arb_state_t;
   typedef enum logic {GRANT_FETCH, GRANT_DATA} grant_t;

   localparam logic [3:0]  BE_WORD   = 4'hF;
   // Clears the byte-offset bits so the bus only ever sees word addresses.
   localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

   // Single requester wins outright; on a conflict the side that did not
   // win last time gets the bus, giving strict alternation under load.
   function automatic grant_t next_grant(input logic   f_req,
                                         input logic   d_req,
                                         input grant_t last);
      grant_t g;
      g = GRANT_FETCH;
      if (f_req && d_req) begin
         if (last == GRANT_FETCH) g = GRANT_DATA;
         else                     g = GRANT_FETCH;
      end else if (d_req) begin
         g = GRANT_DATA;
      end
      return g;
   endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the CPU's fetch and data requesters onto one Avalon-MM master port.
// Latency: req -> strobes next cycle -> ack + rdata the cycle after acceptance (2 cycles min, +1 per waitrequest).
// Backpressure: waitrequest holds the latched transfer in REQ with all bus outputs frozen; requesters hold *_req until ack.
//
// Ports: clk/reset (async active-low); fetch side f_req/f_addr -> f_ack/f_rdata;
// data side d_req/d_we/d_addr/d_be/d_wdata -> d_ack/d_rdata; busy; Avalon master
// address/read/write/writedata/byteenable out, waitrequest/readdata in.
module mem_bus_arbiter
   import mips_bus_pkg::*;
#(
   parameter logic RESET_LAST_GRANT = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        f_req,
   input  logic [31:0] f_addr,
   output logic        f_ack,
   output logic [31:0] f_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [3:0]  d_be,
   input  logic [31:0] d_wdata,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        busy,
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   input  logic        waitrequest,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic [31:0] readdata
);

   arb_state_t  state_q;
   grant_t      last_q;
   grant_t      owner_q;
   grant_t      grant_d;
   logic        we_q;
   logic [31:0] address_q;
   logic [31:0] writedata_q;
   logic [3:0]  byteenable_q;
   logic        read_q;
   logic        write_q;
   logic        f_ack_q;
   logic        d_ack_q;
   logic [31:0] f_rdata_q;
   logic [31:0] d_rdata_q;

   assign grant_d = next_grant(f_req, d_req, last_q);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         last_q       <= grant_t'(RESET_LAST_GRANT);
         owner_q      <= GRANT_FETCH;
         we_q         <= 1'b0;
         address_q    <= '0;
         writedata_q  <= '0;
         byteenable_q <= '0;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         f_ack_q      <= 1'b0;
         d_ack_q      <= 1'b0;
         f_rdata_q    <= '0;
         d_rdata_q    <= '0;
      end else begin
         f_ack_q <= 1'b0;
         d_ack_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (f_req || d_req) begin
                  last_q  <= grant_d;
                  owner_q <= grant_d;
                  state_q <= REQ;
                  if (grant_d == GRANT_FETCH) begin
                     // Fetch is always a full-word read; writedata keeps its last value.
                     address_q    <= f_addr & WORD_MASK;
                     byteenable_q <= BE_WORD;
                     we_q         <= 1'b0;
                     read_q       <= 1'b1;
                     write_q      <= 1'b0;
                  end else begin
                     address_q    <= d_addr & WORD_MASK;
                     byteenable_q <= d_be;
                     writedata_q  <= d_wdata;
                     we_q         <= d_we;
                     read_q       <= ~d_we;
                     write_q      <= d_we;
                  end
               end
            end
            REQ: begin
               if (!waitrequest) begin
                  read_q  <= 1'b0;
                  write_q <= 1'b0;
                  state_q <= RESP;
                  if (owner_q == GRANT_FETCH) f_ack_q <= 1'b1;
                  else                        d_ack_q <= 1'b1;
               end
            end
            RESP: begin
               // readdata is valid in this cycle; keep it for the hold period.
               if (owner_q == GRANT_FETCH) f_rdata_q <= readdata;
               else if (!we_q)             d_rdata_q <= readdata;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // During the ack cycle readdata is passed straight through so the word is
   // valid together with the ack; afterwards the captured copy holds it.
   assign f_rdata    = f_ack_q ? readdata : f_rdata_q;
   assign d_rdata    = (d_ack_q && !we_q) ? readdata : d_rdata_q;
   assign f_ack      = f_ack_q;
   assign d_ack      = d_ack_q;
   assign busy       = (state_q != IDLE);
   assign address    = address_q;
   assign read       = read_q;
   assign write      = write_q;
   assign writedata  = writedata_q;
   assign byteenable = byteenable_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table plus scoreboarded acks.
// Latency: n/a.
// Backpressure: waitrequest is driven per vector to exercise stalls.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        f_req, d_req, d_we;
   logic [31:0] f_addr, d_addr, d_wdata;
   logic [3:0]  d_be;
   logic        f_ack, d_ack, busy, read, write, waitrequest;
   logic [31:0] f_rdata, d_rdata, address, writedata;
   logic [3:0]  byteenable;
   logic [31:0] readdata = 32'h0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.RESET_LAST_GRANT(1'b1)) dut (
      .clk(clk), .reset(reset),
      .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_be(d_be), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata), .busy(busy),
      .address(address), .read(read), .write(write), .waitrequest(waitrequest),
      .writedata(writedata), .byteenable(byteenable), .readdata(readdata)
   );

   typedef struct {
      logic        is_data;
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      int          stall;
      logic        drop;
      logic [31:0] exp_addr;
      logic        exp_rd;
      logic        exp_wr;
      logic [3:0]  exp_be;
      logic [31:0] exp_rdata;
   } vec_t;

   typedef struct {
      logic        is_data;
      logic [31:0] rdata;
   } sb_t;

   sb_t         sb_q[$];
   sb_t         mon_e;
   vec_t        vecs[7];
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] d_hold  = 32'h0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Avalon slave: read data appears the cycle after the read is accepted.
   function automatic logic [31:0] mem_model(input logic [31:0] a);
      if (a == 32'hBFC0_0000) return 32'h2402_0005;
      return a ^ 32'hA5A5_0000;
   endfunction

   always @(posedge clk) begin
      if (read && !waitrequest) readdata <= mem_model(address);
   end

   // Ack monitor: every ack pops one scoreboard entry.
   always @(negedge clk) begin
      if (busy) chk("rd_wr_exclusive", {31'b0, read & write}, 32'h0);
      if (f_ack && d_ack) chk("ack_overlap", 32'h1, 32'h0);
      if (f_ack || d_ack) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_ack", {30'b0, d_ack, f_ack}, 32'h0);
         end else begin
            mon_e = sb_q.pop_front();
            chk("ack_port", {31'b0, d_ack}, {31'b0, mon_e.is_data});
            chk("ack_rdata", mon_e.is_data ? d_rdata : f_rdata, mon_e.rdata);
         end
      end
   end

   function automatic vec_t mk(input logic is_data, input logic we, input logic [31:0] addr,
                               input logic [3:0] be, input logic [31:0] wdata, input int stall,
                               input logic drop, input logic [31:0] exp_addr,
                               input logic [3:0] exp_be, input logic [31:0] exp_rdata);
      vec_t v;
      v.is_data = is_data; v.we = we; v.addr = addr; v.be = be; v.wdata = wdata;
      v.stall = stall; v.drop = drop; v.exp_addr = exp_addr;
      v.exp_rd = !(is_data && we); v.exp_wr = is_data && we;
      v.exp_be = exp_be; v.exp_rdata = exp_rdata;
      return v;
   endfunction

   task automatic push_exp(input logic is_data, input logic we, input logic [31:0] rdata);
      sb_t e;
      e.is_data = is_data;
      if (is_data && !we) d_hold = rdata;
      e.rdata = (is_data && we) ? d_hold : rdata;
      sb_q.push_back(e);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      f_req = 1'b0; d_req = 1'b0; waitrequest = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      d_hold = 32'h0;
   endtask

   // Called at a negedge with the DUT idle.
   task automatic run_vec(input vec_t v, input string tag);
      logic [31:0] ack_v;
      f_addr = v.addr; d_addr = v.addr; d_we = v.we; d_be = v.be; d_wdata = v.wdata;
      waitrequest = (v.stall != 0);
      push_exp(v.is_data, v.we, v.exp_rdata);
      if (v.is_data) d_req = 1'b1; else f_req = 1'b1;
      for (int cyc = 1; cyc <= v.stall + 8; cyc++) begin
         @(negedge clk);
         if (cyc <= v.stall + 1) begin
            chk({tag, "_address"}, address, v.exp_addr);
            chk({tag, "_read"}, {31'b0, read}, {31'b0, v.exp_rd});
            chk({tag, "_write"}, {31'b0, write}, {31'b0, v.exp_wr});
            chk({tag, "_be"}, {28'b0, byteenable}, {28'b0, v.exp_be});
            if (v.exp_wr) chk({tag, "_wdata"}, writedata, v.wdata);
            chk({tag, "_busy"}, {31'b0, busy}, 32'h1);
            if (cyc == 1) begin
               // Requester inputs change mid-transfer; the bus must not follow.
               f_addr = ~v.addr; d_addr = ~v.addr; d_wdata = ~v.wdata;
               d_be = ~v.be; d_we = ~v.we;
               if (v.drop) begin f_req = 1'b0; d_req = 1'b0; end
            end
            if (cyc == v.stall + 1) waitrequest = 1'b0;
         end else if (cyc == v.stall + 2) begin
            ack_v = v.is_data ? {31'b0, d_ack} : {31'b0, f_ack};
            chk({tag, "_ack_latency"}, ack_v, 32'h1);
            chk({tag, "_strobes_off"}, {30'b0, read, write}, 32'h0);
            f_req = 1'b0; d_req = 1'b0;
         end else begin
            chk({tag, "_idle_after"}, {29'b0, busy, f_ack, d_ack}, 32'h0);
            break;
         end
      end
   endtask

   initial begin
      int acks;
      int last_ack_cyc;
      f_req = 0; d_req = 0; d_we = 0; f_addr = 0; d_addr = 0; d_be = 0; d_wdata = 0;
      waitrequest = 0;
      reset = 1'b0;
      #2;
      chk("rst_read",  {31'b0, read},  32'h0);
      chk("rst_write", {31'b0, write}, 32'h0);
      chk("rst_acks",  {30'b0, f_ack, d_ack}, 32'h0);
      chk("rst_busy",  {31'b0, busy},  32'h0);
      chk("rst_address", address, 32'h0);
      chk("rst_writedata", writedata, 32'h0);
      chk("rst_byteenable", {28'b0, byteenable}, 32'h0);
      chk("rst_f_rdata", f_rdata, 32'h0);
      chk("rst_d_rdata", d_rdata, 32'h0);
      @(negedge clk);
      reset = 1'b1;

      vecs[0] = mk(0, 0, 32'hBFC0_0000, 4'h0, 32'h0,         0, 0, 32'hBFC0_0000, 4'hF, 32'h2402_0005);
      vecs[1] = mk(1, 1, 32'h0000_1004, 4'h3, 32'hDEAD_BEEF, 3, 0, 32'h0000_1004, 4'h3, 32'h0);
      vecs[2] = mk(0, 0, 32'h0000_0403, 4'h0, 32'h0,         0, 0, 32'h0000_0400, 4'hF, 32'hA5A5_0400);
      vecs[3] = mk(1, 0, 32'h0000_2008, 4'hF, 32'h1111_2222, 1, 1, 32'h0000_2008, 4'hF, 32'hA5A5_2008);
      vecs[4] = mk(1, 0, 32'h0000_300E, 4'hC, 32'h3333_4444, 2, 0, 32'h0000_300C, 4'hC, 32'hA5A5_300C);
      vecs[5] = mk(1, 1, 32'h0000_0044, 4'h8, 32'h1234_5678, 0, 1, 32'h0000_0044, 4'h8, 32'h0);
      vecs[6] = mk(0, 0, 32'h0000_0010, 4'h0, 32'h0,         1, 0, 32'h0000_0010, 4'hF, 32'hA5A5_0010);

      for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));
      chk("sb_empty_vecs", sb_q.size(), 32'h0);

      // Both requesters held: F, D, F, D at one ack every 3 cycles.
      do_reset();
      f_addr = 32'h0000_0100; d_addr = 32'h0000_0200; d_we = 1'b0; d_be = 4'hF;
      waitrequest = 1'b0;
      push_exp(0, 0, mem_model(32'h0000_0100));
      push_exp(1, 0, mem_model(32'h0000_0200));
      push_exp(0, 0, mem_model(32'h0000_0100));
      push_exp(1, 0, mem_model(32'h0000_0200));
      f_req = 1'b1; d_req = 1'b1;
      acks = 0; last_ack_cyc = 0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         @(negedge clk);
         if (f_ack || d_ack) begin
            acks++;
            chk("alt_spacing", cyc - last_ack_cyc, (acks == 1) ? 2 : 3);
            last_ack_cyc = cyc;
            if (acks == 4) begin f_req = 1'b0; d_req = 1'b0; break; end
         end
      end
      chk("alt_ack_count", acks, 4);
      @(negedge clk);
      chk("alt_idle", {31'b0, busy}, 32'h0);
      chk("sb_empty_alt", sb_q.size(), 32'h0);

      // Reset while stalled in REQ: strobes drop asynchronously, no ack follows.
      f_addr = 32'h0000_0040; f_req = 1'b1; waitrequest = 1'b1;
      @(negedge clk);
      chk("rreq_read_on", {31'b0, read}, 32'h1);
      #2 reset = 1'b0;
      #1;
      chk("rreq_read_off", {31'b0, read}, 32'h0);
      chk("rreq_write_off", {31'b0, write}, 32'h0);
      chk("rreq_busy_off", {31'b0, busy}, 32'h0);
      chk("rreq_address", address, 32'h0);
      f_req = 1'b0; waitrequest = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      d_hold = 32'h0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("rreq_no_ack", {30'b0, f_ack, d_ack}, 32'h0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
